// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter: one pop per rising edge of read_enable,
// overflow is sticky. Define UART_TX_FIFO_DROP_CNT_EN to build the saturating dropped-write counter.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     read_enable,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         Tx_Parallel,
    output logic                     Enable,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             re_d;
    logic             overflow_q;

    logic pop;
    logic push;
    logic drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Edge-detect the transmitter load so a long-held read_enable pops once.
    assign pop  = read_enable & ~re_d & ~empty;
    assign push = wr_en & (~full | pop);
    assign drop = wr_en & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_d    <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            re_d <= read_enable;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow_q <= 1'b0;
        else if (ovf_clr)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt_q <= 8'h00;
        else if (ovf_clr)
            drop_cnt_q <= 8'h00;
        else if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_q <= drop_cnt_q + 8'h01;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

    assign Tx_Parallel = empty ? '0 : mem[rd_ptr];
    assign Enable      = ~empty;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized plus directed bench for uart_tx_fifo (DEPTH=4) against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             read_enable = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] Tx_Parallel;
    logic             Enable;
    logic             empty;
    logic             full;
    logic [2:0]       count;
    logic             overflow;
    logic [7:0]       drop_count;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .read_enable (read_enable),
        .ovf_clr     (ovf_clr),
        .Tx_Parallel (Tx_Parallel),
        .Enable      (Enable),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_re_prev = 0;
    bit         m_ovf = 0;
    int         m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_drop_count();
`ifdef UART_TX_FIFO_DROP_CNT_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("enable", 32'(Enable), 32'(q.size() != 0));
        chk("tx_parallel", 32'(Tx_Parallel), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(exp_drop_count()));
    endtask

    task automatic model_reset();
        q.delete();
        m_re_prev = 0;
        m_ovf = 0;
        m_drops = 0;
    endtask

    // One clock: apply inputs, verify the byte the transmitter captures, advance model, check outputs.
    task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit clr);
        bit pop, acc, dropped;
        wr_en = we;
        wr_data = wd;
        read_enable = re;
        ovf_clr = clr;
        pop = re && !m_re_prev && (q.size() > 0);
        acc = we && ((q.size() < DEPTH) || pop);
        dropped = we && !acc;
        if (pop)
            chk("captured", 32'(Tx_Parallel), 32'(q[0]));
        @(posedge clk);
        #1;
        if (pop)
            void'(q.pop_front());
        if (acc)
            q.push_back(wd);
        m_re_prev = re;
        if (clr) begin
            m_ovf = 0;
            m_drops = 0;
        end else if (dropped) begin
            m_ovf = 1;
            if (m_drops < 255)
                m_drops++;
        end
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            cyc(0, 8'h00, 1, 0);
            cyc(0, 8'h00, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        chk("rst_tx", 32'(Tx_Parallel), 32'h00);
        chk("rst_enable", 32'(Enable), 32'h0);

        // Long read_enable gives exactly one pop
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("hold_tx", 32'(Tx_Parallel), 32'h3C);
        chk("hold_count", 32'(count), 32'd1);
        cyc(0, 8'h00, 0, 0);
        drain();

        // Fill then overflow
        for (int i = 1; i <= 5; i++)
            cyc(1, 8'(i), 0, 0);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);

        // Full: write coincident with pop is accepted
        cyc(1, 8'h77, 1, 0);
        chk("fullpush_count", 32'(count), 32'd4);
        chk("fullpush_ovf", 32'(overflow), 32'h1);
        cyc(0, 8'h00, 0, 0);
        drain();

        // Empty pop ignored; push with read edge while empty
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h5A, 1, 0);
        chk("emptypush_count", 32'(count), 32'd1);
        chk("emptypush_head", 32'(Tx_Parallel), 32'h5A);
        cyc(0, 8'h00, 0, 1);
        drain();

        // Saturating drop counter
        for (int i = 0; i < DEPTH + 300; i++)
            cyc(1, 8'($urandom), 0, 0);
        chk("sat_drop", 32'(drop_count), 32'(exp_drop_count()));
        cyc(1, 8'hEE, 0, 1);
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_drop", 32'(drop_count), 32'h0);

        // Asynchronous reset mid-stream
        cyc(1, 8'h11, 0, 0);
        wr_en = 1'b0;
        read_enable = 1'b0;
        ovf_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                wr_en = 1'b0;
                read_enable = 1'b0;
                ovf_clr = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 99) < 60, 8'($urandom),
                $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO directly upstream of the UART transmitter. It buffers bytes produced by the accelerometer/SPI side and presents the head byte show-ahead to the transmitter's parallel input. It asserts the transmitter's enable whenever data is waiting and pops one byte per transmitter load handshake. Overflow is detected and reported, never silently corrupting stored data.

## Interface
- `DEPTH`, 16 — number of byte entries; power of two, ≥ 2.
- `WIDTH`, 8 — data width in bits.
- `clk`  in  1  — system clock; all state updates on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `wr_en`  in  1  — write strobe from producer; one byte per cycle high.
- `wr_data`  in  WIDTH  — byte to write, sampled when `wr_en`=1.
- `read_enable`  in  1  — load handshake from transmitter; level, may stay high ≥ 2 cycles.
- `Tx_Parallel`  out  WIDTH  — head byte, combinational show-ahead; 0 when empty.
- `Enable`  out  1  — transmit request to transmitter; equals `!empty`.
- `empty`  out  1  — no stored bytes.
- `full`  out  1  — DEPTH bytes stored.
- `count`  out  clog2(DEPTH)+1  — stored byte count, 0..DEPTH.
- `overflow`  out  1  — sticky; set when a write is dropped.
- `ovf_clr`  in  1  — synchronous clear of `overflow` (and drop counter).
- `drop_count`  out  8  — dropped-write counter (see Configuration).

## Operation
- Storage: DEPTH×WIDTH array, read pointer, write pointer (clog2(DEPTH) bits, natural wrap at DEPTH), registered `count`.
- Pop detection: `read_enable` registered into `re_d`; pop = `read_enable & !re_d & !empty`. Exactly one pop per rising edge of `read_enable` regardless of its high duration.
- Pop while empty: ignored, no pointer/count change, no flag.
- Push = `wr_en & (!full | pop)`. Write while full with no same-cycle pop: byte dropped, `overflow` set, contents unchanged.
- Simultaneous push and pop: both performed; `count` unchanged; when full, the write is accepted into the slot freed by the pop.
- Push while empty with same-cycle read_enable edge: pop suppressed (empty), push accepted, count becomes 1.
- `empty` = (`count`==0), `full` = (`count`==DEPTH), both derived from registered `count`.
- `ovf_clr` has priority over a same-cycle overflow event: flag ends cleared.
- Memory contents are not reset; everything else is.

## Timing
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `Enable` 0, `Tx_Parallel` 0, `overflow` 0, `drop_count` 0, `re_d` 0.
- Write latency: byte written at edge N is visible on `Tx_Parallel`, `Enable`=1, `count` updated after edge N (cycle N+1).
- Pop: read pointer advances at the first edge where `read_enable` is sampled 1. The transmitter captures `Tx_Parallel` on that same edge, so it receives the pre-pop head; the next byte appears on `Tx_Parallel` in the following cycle.
- `Enable` may remain 1 while transmitter is busy; transmitter ignores it outside idle.
- Reset asserted mid-transfer: FIFO empties immediately (asynchronous); a byte already captured by the transmitter is unaffected.

## Configuration
- `UART_TX_FIFO_DROP_CNT_EN` defined: `drop_count` is an 8-bit counter incremented per dropped write, saturating at 255, cleared by `ovf_clr` (clear wins over same-cycle increment) and by reset.
- Not defined: counter logic is not built; `drop_count` is tied to 8'h00. `overflow` behaviour is identical in both builds.

## Test plan
- Reset with DEPTH=4: after `rst_n` release, `empty`=1, `Enable`=0, `count`=0, `Tx_Parallel`=8'h00.
- Write 8'hA5, 8'h3C; hold `read_enable` high 2 cycles -> exactly one pop, captured byte 8'hA5, `Tx_Parallel`=8'h3C, `count`=1.
- Fill DEPTH=4 with 8'h01..8'h04, write 8'h05 -> `full`=1, `overflow`=1, `drop_count`=1 (macro on) / 0 (off), order out 01..04.
- With `full`=1, `wr_en`=1 (8'h77) coincident with `read_enable` rising -> pop 8'h01, 8'h77 accepted, `count`=4, `overflow` unchanged.
- Empty FIFO, `read_enable` pulse -> no change; simultaneous write 8'h5A + `read_enable` edge -> `count`=1, head 8'h5A.
- Macro on: 300 writes into full FIFO -> `drop_count`=255; `ovf_clr` -> `overflow`=0, `drop_count`=0; `rst_n` low mid-stream -> all outputs at reset values immediately.
